// File: rtl/cnt_mon_pkg.sv
// cnt_mon_pkg: shared FSM state type and default sizing for the counter step monitor
package cnt_mon_pkg;
    localparam int DEF_CNT_W      = 4;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_STEP_W     = 8;
    typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;
endpackage

// File: rtl/cnt_fifo.sv
// cnt_fifo: first-word-fall-through FIFO, head shown on dout while non-empty
// ports: clk, rst_n (async active-low), push/din write, pop read (ignored when empty),
//        dout head (last popped value when empty, 0 after reset), full, empty
module cnt_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic [W-1:0] last;
    logic         do_pop, do_push;
    // extra pointer bit tells full from empty when the indices match
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? last : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last   <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + (AW+1)'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + (AW+1)'(1) : rd_ptr;
            last   <= do_pop ? mem[rd_ptr[AW-1:0]] : last;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/cnt_step_monitor.sv
// cnt_step_monitor: checks a sampled counter for +1 steps and buffers accepted values
// ports: clk_100M, rst_ (async active-low), cnt_in monitored counter, clr_err clears flags and
//        restarts tracking, out_data/out_valid/out_ready FIFO head handshake,
//        step_cnt saturating legal-step count, err sticky bad step, ovf sticky FIFO overflow
module cnt_step_monitor
    import cnt_mon_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int STEP_W     = DEF_STEP_W
) (
    input  logic              clk_100M,
    input  logic              rst_,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              clr_err,
    output logic [CNT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [STEP_W-1:0] step_cnt,
    output logic              err,
    output logic              ovf
);
    state_t           state, state_nx;
    logic [CNT_W-1:0] s1, s2, s2_inc;
    logic             change, push, inc, bad, full, empty, pop, drop;
    assign change    = s1 != s2;
    assign s2_inc    = s2 + CNT_W'(1);
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign drop      = push && full && !pop;
    always_comb begin
        state_nx = state;
        push     = 1'b0;
        inc      = 1'b0;
        bad      = 1'b0;
        if (clr_err) state_nx = IDLE;
        else if (change) begin
            case (state)
                IDLE: begin
                    push     = 1'b1;
                    state_nx = TRACK;
                end
                TRACK: begin
                    push     = s1 == s2_inc;
                    inc      = s1 == s2_inc;
                    bad      = s1 != s2_inc;
                    state_nx = (s1 == s2_inc) ? TRACK : ERROR;
                end
                default: state_nx = state;
            endcase
        end
    end
    always_ff @(posedge clk_100M or negedge rst_) begin
        if (!rst_) begin
            s1       <= '0;
            s2       <= '0;
            state    <= IDLE;
            step_cnt <= '0;
            err      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            s1       <= cnt_in;
            s2       <= s1;
            state    <= state_nx;
            step_cnt <= (inc && step_cnt != '1) ? step_cnt + STEP_W'(1) : step_cnt;
            err      <= clr_err ? 1'b0 : err | bad;
            ovf      <= clr_err ? 1'b0 : ovf | drop;
        end
    end
    cnt_fifo #(.W(CNT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_100M),
        .rst_n (rst_),
        .push  (push),
        .din   (s1),
        .pop   (pop),
        .dout  (out_data),
        .full  (full),
        .empty (empty)
    );
endmodule

// File: tb/tb_cnt_step_monitor.sv
// tb_cnt_step_monitor: directed stimulus with a scoreboard queue checked by a pop monitor
module tb_cnt_step_monitor;
    logic       clk_100M = 1'b0;
    logic       rst_;
    logic [3:0] cnt_in;
    logic       clr_err;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] step_cnt;
    logic       err;
    logic       ovf;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];

    cnt_step_monitor dut (
        .clk_100M  (clk_100M),
        .rst_      (rst_),
        .cnt_in    (cnt_in),
        .clr_err   (clr_err),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .step_cnt  (step_cnt),
        .err       (err),
        .ovf       (ovf)
    );

    always #5 clk_100M = ~clk_100M;

    always @(negedge clk_100M) begin
        if (rst_ && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got=%0d exp=none", out_data);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL pop_data got=%0d exp=%0d", out_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100M);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input bit exp_push);
        cnt_in = v;
        if (exp_push) exp_q.push_back(v);
        tick(2);
    endtask

    task automatic lat_drive(input logic [3:0] v);
        cnt_in = v;
        exp_q.push_back(v);
        tick(1);
        chk("lat_valid_n", 32'(out_valid), 0);
        tick(1);
        chk("lat_valid_n1", 32'(out_valid), 1);
        chk("lat_data", 32'(out_data), 32'(v));
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    initial begin
        rst_ = 1'b0;
        cnt_in = 4'd0;
        out_ready = 1'b1;
        clr_err = 1'b0;
        tick(3);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_step", 32'(step_cnt), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ovf", 32'(ovf), 0);
        rst_ = 1'b1;
        tick(2);
        lat_drive(4'd1);
        lat_drive(4'd2);
        lat_drive(4'd3);
        chk("step_after_123", 32'(step_cnt), 2);
        chk("err_after_123", 32'(err), 0);
        drive(4'd4, 1);
        drive(4'd5, 1);
        chk("step_at_5", 32'(step_cnt), 4);
        cnt_in = 4'd7;
        tick(1);
        chk("err_not_yet", 32'(err), 0);
        tick(1);
        chk("err_set", 32'(err), 1);
        drive(4'd8, 0);
        chk("err_sticky", 32'(err), 1);
        chk("step_frozen", 32'(step_cnt), 4);
        pulse_clr();
        chk("err_cleared", 32'(err), 0);
        drive(4'd9, 1);
        for (int v = 10; v < 18; v++) drive(4'(v), 1);
        chk("step_wrap", 32'(step_cnt), 12);
        chk("err_wrap", 32'(err), 0);
        tick(2);
        out_ready = 1'b0;
        for (int v = 2; v < 6; v++) drive(4'(v), 1);
        chk("ovf_at_full", 32'(ovf), 0);
        chk("valid_full", 32'(out_valid), 1);
        drive(4'd6, 0);
        chk("ovf_set", 32'(ovf), 1);
        drive(4'd7, 0);
        chk("step_ovf", 32'(step_cnt), 18);
        out_ready = 1'b1;
        tick(6);
        chk("drain_valid", 32'(out_valid), 0);
        chk("hold_last", 32'(out_data), 5);
        chk("drain_q", 32'(exp_q.size()), 0);
        pulse_clr();
        chk("ovf_cleared", 32'(ovf), 0);
        out_ready = 1'b0;
        for (int v = 8; v < 12; v++) drive(4'(v), 1);
        chk("ovf_full2", 32'(ovf), 0);
        cnt_in = 4'd12;
        exp_q.push_back(4'd12);
        tick(1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("ovf_simul", 32'(ovf), 0);
        drive(4'd13, 0);
        chk("ovf_count4", 32'(ovf), 1);
        out_ready = 1'b1;
        tick(6);
        chk("drain2_valid", 32'(out_valid), 0);
        chk("drain2_q", 32'(exp_q.size()), 0);
        chk("step_simul", 32'(step_cnt), 23);
        out_ready = 1'b0;
        pulse_clr();
        drive(4'd2, 1);
        drive(4'd3, 1);
        cnt_in = 4'd5;
        tick(2);
        chk("pre_rst_err", 32'(err), 1);
        chk("pre_rst_valid", 32'(out_valid), 1);
        chk("pre_rst_step", 32'(step_cnt), 24);
        #3;
        rst_ = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_step", 32'(step_cnt), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_ovf", 32'(ovf), 0);
        exp_q.delete();
        out_ready = 1'b1;
        tick(2);
        rst_ = 1'b1;
        exp_q.push_back(4'd5);
        tick(1);
        chk("rel_not_yet", 32'(out_valid), 0);
        tick(1);
        chk("rel_valid", 32'(out_valid), 1);
        chk("rel_data", 32'(out_data), 5);
        tick(3);
        chk("rel_q", 32'(exp_q.size()), 0);
        chk("rel_step", 32'(step_cnt), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
